// File: rtl/fifo_ctrl_4w16b.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ctrl_4w16b
// Purpose  : Turns a 4-word x 16-bit single-port RAM into a 5-entry FIFO.
//            The four RAM words are backed by one registered head word that
//            feeds the consumer directly. The single RAM port is shared, one
//            cycle at a time, between producer writes and head refills.
// Ports    : clk, rst              - clock and synchronous active-high reset
//            push_data/valid/ready - producer interface (ready is comb)
//            pop_data/valid/ready  - consumer interface (data/valid registered)
//            count, full, afull    - occupancy 0..5 and derived flags
//            ram_in/addr/load      - drive the RAM
//            ram_out               - RAM read data, comb on ram_addr
//            stall_cnt             - only with FIFO_STALL_CNT_EN: saturating
//                                    count of cycles a push was refused
// Config   : `define FIFO_STALL_CNT_EN to add the stall_cnt port and counter.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ctrl_4w16b #(
    parameter int AFULL_THRESH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] push_data,
    input  logic        push_valid,
    output logic        push_ready,
    output logic [15:0] pop_data,
    output logic        pop_valid,
    input  logic        pop_ready,
    output logic [2:0]  count,
    output logic        full,
    output logic        afull,
    output logic [15:0] ram_in,
    output logic [1:0]  ram_addr,
    output logic        ram_load,
    input  logic [15:0] ram_out
`ifdef FIFO_STALL_CNT_EN
    ,
    output logic [7:0]  stall_cnt
`endif
);

    localparam logic [2:0] c_ram_depth   = 3'd4;
    localparam logic [2:0] c_fifo_depth  = 3'd5;
    localparam logic [2:0] c_afull_thresh = 3'(AFULL_THRESH);

    logic [1:0]  r_rd_ptr;
    logic [1:0]  r_wr_ptr;
    logic [2:0]  r_ram_cnt;
    logic [15:0] r_head;
    logic        r_head_vld;

    logic        w_pop_fire;
    logic        w_push_fire;
    logic        w_head_free;
    logic        w_refill;
    logic        w_bypass;
    logic        w_store;

    // The head slot is free if it is empty or being drained this cycle.
    // A free head is always refilled from RAM first so that ordering holds;
    // bypass is only allowed when the RAM holds nothing older.
    assign w_pop_fire  = r_head_vld & pop_ready;
    assign w_head_free = ~r_head_vld | w_pop_fire;
    assign w_refill    = w_head_free & (r_ram_cnt != 3'd0);
    assign w_bypass    = w_head_free & (r_ram_cnt == 3'd0);
    assign w_store     = ~w_head_free;
    assign w_push_fire = push_valid & push_ready;

    always_comb begin
        push_ready = 1'b0;
        ram_addr   = r_rd_ptr;
        ram_in     = push_data;
        ram_load   = 1'b0;
        if (w_bypass) begin
            push_ready = 1'b1;
        end else if (w_store) begin
            push_ready = (r_ram_cnt < c_ram_depth);
            ram_addr   = r_wr_ptr;
            // Never corrupt RAM contents while the controller is in reset.
            ram_load   = w_push_fire & ~rst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr   <= 2'd0;
            r_wr_ptr   <= 2'd0;
            r_ram_cnt  <= 3'd0;
            r_head     <= 16'd0;
            r_head_vld <= 1'b0;
        end else if (w_refill) begin
            // ram_out is addressed by rd_ptr this cycle.
            r_head     <= ram_out;
            r_head_vld <= 1'b1;
            r_rd_ptr   <= r_rd_ptr + 2'd1;
            r_ram_cnt  <= r_ram_cnt - 3'd1;
        end else if (w_bypass) begin
            if (w_push_fire) begin
                r_head     <= push_data;
                r_head_vld <= 1'b1;
            end else begin
                r_head_vld <= 1'b0;
            end
        end else if (w_push_fire) begin
            r_wr_ptr  <= r_wr_ptr + 2'd1;
            r_ram_cnt <= r_ram_cnt + 3'd1;
        end
    end

    assign pop_data  = r_head;
    assign pop_valid = r_head_vld;
    assign count     = r_ram_cnt + {2'b00, r_head_vld};
    assign full      = (count == c_fifo_depth);
    assign afull     = (count >= c_afull_thresh);

`ifdef FIFO_STALL_CNT_EN
    logic [7:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 8'd0;
        end else if (push_valid && !push_ready && (r_stall_cnt != 8'hFF)) begin
            r_stall_cnt <= r_stall_cnt + 8'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl_4w16b.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_ctrl_4w16b
// Purpose  : Self-checking bench for fifo_ctrl_4w16b with a behavioural
//            4x16 RAM attached. Directed vector table plus hand sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl_4w16b;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] push_data;
    logic        push_valid;
    logic        push_ready;
    logic [15:0] pop_data;
    logic        pop_valid;
    logic        pop_ready;
    logic [2:0]  count;
    logic        full;
    logic        afull;
    logic [15:0] ram_in;
    logic [1:0]  ram_addr;
    logic        ram_load;
    logic [15:0] ram_out;
`ifdef FIFO_STALL_CNT_EN
    logic [7:0]  stall_cnt;
`endif

    logic [15:0] mem [4];

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    fifo_ctrl_4w16b #(.AFULL_THRESH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .push_data  (push_data),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .pop_data   (pop_data),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .count      (count),
        .full       (full),
        .afull      (afull),
        .ram_in     (ram_in),
        .ram_addr   (ram_addr),
        .ram_load   (ram_load),
        .ram_out    (ram_out)
`ifdef FIFO_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    // RAM4W16B: synchronous write, combinational read.
    always @(posedge clk) begin
        if (ram_load) mem[ram_addr] <= ram_in;
    end
    assign ram_out = mem[ram_addr];

    typedef struct {
        logic        pv;
        logic [15:0] pd;
        logic        pr;
        logic        e_prdy;
        logic        e_load;
        logic [1:0]  e_addr;
        logic        e_pv;
        logic [15:0] e_pd;
        logic        e_chkd;
        logic [2:0]  e_cnt;
        logic        e_full;
        logic        e_afull;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic pv, input logic [15:0] pd, input logic pr,
                       input logic e_prdy, input logic e_load, input logic [1:0] e_addr,
                       input logic e_pv, input logic [15:0] e_pd, input logic e_chkd,
                       input logic [2:0] e_cnt, input logic e_full, input logic e_afull);
        vec_t v;
        v.pv = pv; v.pd = pd; v.pr = pr;
        v.e_prdy = e_prdy; v.e_load = e_load; v.e_addr = e_addr;
        v.e_pv = e_pv; v.e_pd = e_pd; v.e_chkd = e_chkd;
        v.e_cnt = e_cnt; v.e_full = e_full; v.e_afull = e_afull;
        vecs.push_back(v);
    endtask

    // Called at posedge+1: drive inputs for the coming cycle.
    task automatic drive(input logic pv, input logic [15:0] pd, input logic pr);
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int sent;
    int rcvd;
    int cyc;

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 16'h0000;
        rst = 1'b1;
        drive(1'b0, 16'h0000, 1'b0);

        // Each row: inputs for the cycle, then outputs seen mid-cycle
        // (comb outputs for this cycle; registered outputs from the prior edge).
        //   pv  pd        pr    prdy load addr  pv  pd      chk  cnt  full afull
        // Idle after reset
        add(0, 16'h0000, 0,    1, 0, 2'd0,  0, 16'h0000, 1, 3'd0, 0, 0);
        add(0, 16'h0000, 0,    1, 0, 2'd0,  0, 16'h0000, 0, 3'd0, 0, 0);
        add(0, 16'h0000, 0,    1, 0, 2'd0,  0, 16'h0000, 0, 3'd0, 0, 0);
        // Bypass push into empty FIFO
        add(1, 16'h5555, 0,    1, 0, 2'd0,  0, 16'h0000, 0, 3'd0, 0, 0);
        // Fill the RAM behind the head
        add(1, 16'hFFFF, 0,    1, 1, 2'd0,  1, 16'h5555, 1, 3'd1, 0, 0);
        add(1, 16'hAAAA, 0,    1, 1, 2'd1,  1, 16'h5555, 1, 3'd2, 0, 0);
        add(1, 16'h0FF0, 0,    1, 1, 2'd2,  1, 16'h5555, 1, 3'd3, 0, 0);
        add(1, 16'h1234, 0,    1, 1, 2'd3,  1, 16'h5555, 1, 3'd4, 0, 1);
        // Full: push refused, nothing changes
        add(1, 16'hDEAD, 0,    0, 0, 2'd0,  1, 16'h5555, 1, 3'd5, 1, 1);
        add(0, 16'h0000, 0,    0, 0, 2'd0,  1, 16'h5555, 1, 3'd5, 1, 1);
        // Drain at one word per cycle; first pop also offers a push that must stall
        add(1, 16'h9999, 1,    0, 0, 2'd0,  1, 16'h5555, 1, 3'd5, 1, 1);
        add(0, 16'h0000, 1,    0, 0, 2'd1,  1, 16'hFFFF, 1, 3'd4, 0, 1);
        add(0, 16'h0000, 1,    0, 0, 2'd2,  1, 16'hAAAA, 1, 3'd3, 0, 0);
        add(0, 16'h0000, 1,    0, 0, 2'd3,  1, 16'h0FF0, 1, 3'd2, 0, 0);
        add(0, 16'h0000, 1,    1, 0, 2'd0,  1, 16'h1234, 1, 3'd1, 0, 0);
        add(0, 16'h0000, 1,    1, 0, 2'd0,  0, 16'h0000, 0, 3'd0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].pv, vecs[i].pd, vecs[i].pr);
            @(negedge clk);
            chk($sformatf("v%0d push_ready", i), {31'd0, push_ready}, {31'd0, vecs[i].e_prdy});
            chk($sformatf("v%0d ram_load", i),   {31'd0, ram_load},   {31'd0, vecs[i].e_load});
            chk($sformatf("v%0d ram_addr", i),   {30'd0, ram_addr},   {30'd0, vecs[i].e_addr});
            if (vecs[i].e_load)
                chk($sformatf("v%0d ram_in", i), {16'd0, ram_in},     {16'd0, vecs[i].pd});
            chk($sformatf("v%0d pop_valid", i),  {31'd0, pop_valid},  {31'd0, vecs[i].e_pv});
            if (vecs[i].e_chkd)
                chk($sformatf("v%0d pop_data", i), {16'd0, pop_data}, {16'd0, vecs[i].e_pd});
            chk($sformatf("v%0d count", i),      {29'd0, count},      {29'd0, vecs[i].e_cnt});
            chk($sformatf("v%0d full", i),       {31'd0, full},       {31'd0, vecs[i].e_full});
            chk($sformatf("v%0d afull", i),      {31'd0, afull},      {31'd0, vecs[i].e_afull});
            next_cycle();
        end

        // Streaming with about two words in flight, pointers wrap twice.
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 10 && cyc < 200) begin
            drive(sent < 10, 16'(sent + 1), (count >= 3'd2) || (sent == 10));
            @(negedge clk);
            if (push_valid && push_ready) sent++;
            if (pop_valid && pop_ready) begin
                chk("stream pop_data", {16'd0, pop_data}, 32'(rcvd + 1));
                rcvd++;
            end
            cyc++;
            next_cycle();
        end
        chk("stream words received", 32'(rcvd), 32'd10);
        drive(1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        chk("stream drained count", {29'd0, count}, 32'd0);
        chk("stream drained pop_valid", {31'd0, pop_valid}, 32'd0);
        next_cycle();

        // Reset mid-stream with three words held.
        drive(1'b1, 16'h0A01, 1'b0); next_cycle();
        drive(1'b1, 16'h0A02, 1'b0); next_cycle();
        drive(1'b1, 16'h0A03, 1'b0);
        @(negedge clk);
        chk("pre-reset push_ready", {31'd0, push_ready}, 32'd1);
        next_cycle();
        drive(1'b1, 16'hDEAD, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("pre-reset count", {29'd0, count}, 32'd3);
        chk("ram_load in reset", {31'd0, ram_load}, 32'd0);
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        chk("post-reset count", {29'd0, count}, 32'd0);
        chk("post-reset pop_valid", {31'd0, pop_valid}, 32'd0);
        chk("post-reset pop_data", {16'd0, pop_data}, 32'd0);
        next_cycle();
        drive(1'b1, 16'hBEEF, 1'b0);
        @(negedge clk);
        chk("post-reset push_ready", {31'd0, push_ready}, 32'd1);
        next_cycle();
        drive(1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        chk("post-reset pop_valid 1", {31'd0, pop_valid}, 32'd1);
        chk("post-reset pop_data", {16'd0, pop_data}, 32'h0000BEEF);
        next_cycle();
        drive(1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        chk("post-pop count", {29'd0, count}, 32'd0);
        next_cycle();

`ifdef FIFO_STALL_CNT_EN
        @(negedge clk);
        chk("stall_cnt after reset", {24'd0, stall_cnt}, 32'd0);
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'(16'h0C00 + i), 1'b0);
            next_cycle();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0BAD, 1'b0);
            next_cycle();
        end
        drive(1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        chk("stall_cnt refused 3", {24'd0, stall_cnt}, 32'd3);
        chk("stall full", {31'd0, full}, 32'd1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("stall_cnt cleared", {24'd0, stall_cnt}, 32'd0);
        next_cycle();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
